// File: rtl/utf8_stream_decoder_pkg.sv
// Shared types and constants for the UTF-8 byte-stream decoder.
// Lead-byte classes and the replacement code point are also used by the terminal stage.
package utf8_stream_decoder_pkg;

    typedef enum logic [1:0] {
        S_LEAD,
        S_CONT,
        S_HOLD
    } state_t;

    localparam logic [20:0] REPLACEMENT_CHARACTER = 21'h00FFFD;

    // Sequence length reported by the lead classifier (0 = not a valid lead).
    localparam logic [2:0] LEN_NONE  = 3'd0;
    localparam logic [2:0] LEN_ASCII = 3'd1;
    localparam logic [2:0] LEN_TWO   = 3'd2;
    localparam logic [2:0] LEN_THREE = 3'd3;
    localparam logic [2:0] LEN_FOUR  = 3'd4;

    typedef struct packed {
        logic [2:0] len;
        logic [6:0] payload;
        logic       invalid;
    } lead_class_t;

endpackage

// File: rtl/utf8_lead_classify.sv
// Combinational lead-byte classifier: sequence length, payload bits, invalid flag.
// C0/C1 (always overlong) and F5-FF (beyond U+10FFFF) are rejected here.
module utf8_lead_classify
    import utf8_stream_decoder_pkg::*;
(
    input  logic [7:0]  lead,
    output lead_class_t cls
);

    always_comb begin
        cls = '{len: LEN_NONE, payload: '0, invalid: 1'b1};
        if (!lead[7]) begin
            cls = '{len: LEN_ASCII, payload: lead[6:0], invalid: 1'b0};
        end else if (lead >= 8'hC2 && lead <= 8'hDF) begin
            cls = '{len: LEN_TWO, payload: {2'b00, lead[4:0]}, invalid: 1'b0};
        end else if (lead[7:4] == 4'hE) begin
            cls = '{len: LEN_THREE, payload: {3'b000, lead[3:0]}, invalid: 1'b0};
        end else if (lead >= 8'hF0 && lead <= 8'hF4) begin
            cls = '{len: LEN_FOUR, payload: {4'b0000, lead[2:0]}, invalid: 1'b0};
        end
    end

endmodule

// File: rtl/utf8_stream_decoder.sv
// UTF-8 byte stream to 21-bit code point decoder with paced, back-pressured output.
// Malformed input yields REPLACEMENT; a byte that truncates a sequence is replayed as a lead.
module utf8_stream_decoder
    import utf8_stream_decoder_pkg::*;
#(
    parameter int unsigned MIN_GAP     = 8,
    parameter logic [20:0] REPLACEMENT = REPLACEMENT_CHARACTER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_available,
    output logic        byte_ready,
    input  logic        ready_n,
    output logic [20:0] unicode,
    output logic        unicode_available,
    output logic        decode_error
);

    state_t      state, state_next;
    logic [20:0] acc, acc_next;
    logic [1:0]  need, need_next;
    logic [2:0]  len, len_next;
    logic [20:0] pending, pending_next;
    logic        pending_err, pending_err_next;
    logic [7:0]  replay, replay_next;
    logic        replay_valid, replay_valid_next;
    logic [15:0] gap;
    logic        alive;
    logic        accept;
    logic        emit;
    logic        out_of_range;
    logic [20:0] acc_shift;
    logic [7:0]  lead;
    lead_class_t cls;

    // A held replay byte takes priority over the input port as the next lead.
    assign lead       = replay_valid ? replay : byte_in;
    assign byte_ready = alive && (state != S_HOLD) && !replay_valid;
    assign accept     = byte_available && byte_ready;
    assign acc_shift  = {acc[14:0], byte_in[5:0]};

    assign out_of_range =
        ((len == LEN_THREE) && ((acc_shift < 21'h000800) ||
                                ((acc_shift >= 21'h00D800) && (acc_shift <= 21'h00DFFF)))) ||
        ((len == LEN_FOUR)  && ((acc_shift < 21'h010000) || (acc_shift > 21'h10FFFF)));

    utf8_lead_classify u_classify (
        .lead (lead),
        .cls  (cls)
    );

    always_comb begin
        state_next        = state;
        acc_next          = acc;
        need_next         = need;
        len_next          = len;
        pending_next      = pending;
        pending_err_next  = pending_err;
        replay_next       = replay;
        replay_valid_next = replay_valid;
        emit              = 1'b0;
        case (state)
            S_LEAD: begin
                if (replay_valid || accept) begin
                    replay_valid_next = 1'b0;
                    if (cls.invalid) begin
                        pending_next     = REPLACEMENT;
                        pending_err_next = 1'b1;
                        state_next       = S_HOLD;
                    end else if (cls.len == LEN_ASCII) begin
                        pending_next     = {14'd0, cls.payload};
                        pending_err_next = 1'b0;
                        state_next       = S_HOLD;
                    end else begin
                        acc_next   = {14'd0, cls.payload};
                        need_next  = 2'(cls.len - 3'd1);
                        len_next   = cls.len;
                        state_next = S_CONT;
                    end
                end
            end
            S_CONT: begin
                if (accept) begin
                    if (byte_in[7:6] == 2'b10) begin
                        acc_next  = acc_shift;
                        need_next = need - 2'd1;
                        if (need == 2'd1) begin
                            pending_next     = out_of_range ? REPLACEMENT : acc_shift;
                            pending_err_next = out_of_range;
                            state_next       = S_HOLD;
                        end
                    end else begin
                        pending_next      = REPLACEMENT;
                        pending_err_next  = 1'b1;
                        replay_next       = byte_in;
                        replay_valid_next = 1'b1;
                        state_next        = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!ready_n && (gap == '0)) begin
                    emit       = 1'b1;
                    state_next = S_LEAD;
                end
            end
            default: state_next = S_LEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_LEAD;
            acc               <= '0;
            need              <= '0;
            len               <= '0;
            pending           <= '0;
            pending_err       <= 1'b0;
            replay            <= '0;
            replay_valid      <= 1'b0;
            gap               <= '0;
            alive             <= 1'b0;
            unicode           <= '0;
            unicode_available <= 1'b0;
            decode_error      <= 1'b0;
        end else begin
            state             <= state_next;
            acc               <= acc_next;
            need              <= need_next;
            len               <= len_next;
            pending           <= pending_next;
            pending_err       <= pending_err_next;
            replay            <= replay_next;
            replay_valid      <= replay_valid_next;
            alive             <= 1'b1;
            unicode_available <= emit;
            decode_error      <= emit && pending_err;
            if (emit) begin
                unicode <= pending;
                gap     <= 16'(MIN_GAP - 1);
            end else if (gap != '0) begin
                gap <= gap - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Self-checking bench for utf8_stream_decoder: directed vector table, corner sequences,
// and randomized byte streams compared against a sequence-level reference decoder.
module tb_utf8_stream_decoder;

    localparam int unsigned MIN_GAP = 8;
    localparam logic [20:0] FFFD    = 21'h00FFFD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        byte_available = 1'b0;
    logic        byte_ready;
    logic        ready_n = 1'b0;
    logic [20:0] unicode;
    logic        unicode_available;
    logic        decode_error;

    always #5 clk = ~clk;

    utf8_stream_decoder #(
        .MIN_GAP     (MIN_GAP),
        .REPLACEMENT (FFFD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .byte_in           (byte_in),
        .byte_available    (byte_available),
        .byte_ready        (byte_ready),
        .ready_n           (ready_n),
        .unicode           (unicode),
        .unicode_available (unicode_available),
        .decode_error      (decode_error)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [20:0] cp;
        logic        err;
        int unsigned at;
    } obs_t;

    obs_t obs[$];
    int   stray_err = 0;

    always @(negedge clk) begin
        if (unicode_available) obs.push_back('{unicode, decode_error, cyc});
        else if (decode_error) stray_err++;
    end

    int tests = 0;
    int fails = 0;
    bit rn_rand = 1'b0;
    int unsigned last_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rn_rand) ready_n = ($urandom_range(3) == 0);
    endtask

    task automatic send(input logic [7:0] b, input bit rand_idle);
        int unsigned waited;
        bit done;
        waited = 0;
        done = 1'b0;
        while (!done && waited <= 500) begin
            if (rand_idle && $urandom_range(3) == 0) begin
                byte_available = 1'b0;
            end else begin
                byte_in = b;
                byte_available = 1'b1;
                done = byte_ready;
            end
            tick();
            waited++;
        end
        byte_available = 1'b0;
        if (!done) check("send_timeout", 0, 1);
        else last_accept = cyc;
    endtask

    task automatic wait_obs(input int unsigned n, input string name);
        int unsigned t;
        t = 0;
        while (obs.size() < n && t < n * (MIN_GAP + 8) + 200) begin
            tick();
            t++;
        end
        repeat (2 * MIN_GAP + 4) tick();
        check(name, obs.size(), n);
    endtask

    task automatic check_gaps(input string name);
        for (int i = 1; i < obs.size(); i++)
            check(name, (obs[i].at - obs[i-1].at) >= MIN_GAP, 1);
    endtask

    // Sequence-level reference decoder over a whole byte stream
    logic [20:0] exp_cp[$];
    logic        exp_err[$];
    logic [7:0]  stream[$];

    function automatic void push_exp(input int unsigned cp, input bit err);
        exp_cp.push_back(21'(cp));
        exp_err.push_back(err);
    endfunction

    function automatic void ref_decode(input logic [7:0] q[$]);
        int unsigned i, b, c, len, cp, k;
        bit trunc, bad;
        exp_cp.delete();
        exp_err.delete();
        i = 0;
        while (i < q.size()) begin
            b = q[i];
            len = 0;
            cp = 0;
            if (b < 'h80) begin
                push_exp(b, 0);
                i++;
                continue;
            end
            if (b >= 'hC2 && b <= 'hDF) begin len = 2; cp = b - 'hC0; end
            else if (b >= 'hE0 && b <= 'hEF) begin len = 3; cp = b - 'hE0; end
            else if (b >= 'hF0 && b <= 'hF4) begin len = 4; cp = b - 'hF0; end
            else begin
                push_exp('hFFFD, 1);
                i++;
                continue;
            end
            trunc = 0;
            k = 1;
            while (k < len && !trunc) begin
                if (i + k >= q.size()) return;
                c = q[i+k];
                if (c < 'h80 || c > 'hBF) trunc = 1;
                else begin
                    cp = cp * 64 + (c - 'h80);
                    k++;
                end
            end
            if (trunc) begin
                push_exp('hFFFD, 1);
                i += k;
                continue;
            end
            bad = (len == 3 && (cp < 'h800 || (cp >= 'hD800 && cp <= 'hDFFF))) ||
                  (len == 4 && (cp < 'h10000 || cp > 'h10FFFF));
            push_exp(bad ? 'hFFFD : cp, bad);
            i += len;
        end
    endfunction

    function automatic void encode(input int unsigned cp);
        if (cp < 'h80) begin
            stream.push_back(8'(cp));
        end else if (cp < 'h800) begin
            stream.push_back(8'('hC0 | (cp >> 6)));
            stream.push_back(8'('h80 | (cp & 63)));
        end else if (cp < 'h10000) begin
            stream.push_back(8'('hE0 | (cp >> 12)));
            stream.push_back(8'('h80 | ((cp >> 6) & 63)));
            stream.push_back(8'('h80 | (cp & 63)));
        end else begin
            stream.push_back(8'('hF0 | (cp >> 18)));
            stream.push_back(8'('h80 | ((cp >> 12) & 63)));
            stream.push_back(8'('h80 | ((cp >> 6) & 63)));
            stream.push_back(8'('h80 | (cp & 63)));
        end
    endfunction

    function automatic void gen_stream(input int unsigned n);
        stream.delete();
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(4))
                0: stream.push_back(8'($urandom_range(127)));
                1: encode($urandom_range('h80, 'h7FF));
                2: encode($urandom_range('h800, 'hFFFF));
                3: encode($urandom_range('h10000, 'h10FFFF));
                default: stream.push_back(8'($urandom_range('h80, 'hFF)));
            endcase
        end
        stream.push_back(8'h20);
    endfunction

    typedef struct packed {
        logic [2:0]        n;
        logic [0:3][7:0]   b;
        logic [1:0]        ne;
        logic [0:1][20:0]  e;
        logic [0:1]        er;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{n: 1, b: {8'h41, 8'h00, 8'h00, 8'h00}, ne: 1, e: {21'h41,    21'h0},  er: 2'b00};
        vt[1]  = '{n: 2, b: {8'hC3, 8'hA9, 8'h00, 8'h00}, ne: 1, e: {21'hE9,    21'h0},  er: 2'b00};
        vt[2]  = '{n: 3, b: {8'hE2, 8'h82, 8'hAC, 8'h00}, ne: 1, e: {21'h20AC,  21'h0},  er: 2'b00};
        vt[3]  = '{n: 4, b: {8'hF0, 8'h9F, 8'h98, 8'h80}, ne: 1, e: {21'h1F600, 21'h0},  er: 2'b00};
        vt[4]  = '{n: 2, b: {8'hC0, 8'h80, 8'h00, 8'h00}, ne: 2, e: {FFFD,      FFFD},   er: 2'b11};
        vt[5]  = '{n: 3, b: {8'hED, 8'hA0, 8'h80, 8'h00}, ne: 1, e: {FFFD,      21'h0},  er: 2'b10};
        vt[6]  = '{n: 4, b: {8'hF4, 8'h90, 8'h80, 8'h80}, ne: 1, e: {FFFD,      21'h0},  er: 2'b10};
        vt[7]  = '{n: 3, b: {8'hE2, 8'h82, 8'h41, 8'h00}, ne: 2, e: {FFFD,      21'h41}, er: 2'b10};
        vt[8]  = '{n: 3, b: {8'hE0, 8'h9F, 8'hBF, 8'h00}, ne: 1, e: {FFFD,      21'h0},  er: 2'b10};
        vt[9]  = '{n: 4, b: {8'hF4, 8'h8F, 8'hBF, 8'hBF}, ne: 1, e: {21'h10FFFF,21'h0},  er: 2'b00};
        vt[10] = '{n: 3, b: {8'hEF, 8'hBF, 8'hBF, 8'h00}, ne: 1, e: {21'hFFFF,  21'h0},  er: 2'b00};
        vt[11] = '{n: 1, b: {8'hF5, 8'h00, 8'h00, 8'h00}, ne: 1, e: {FFFD,      21'h0},  er: 2'b10};
        vt[12] = '{n: 2, b: {8'hDF, 8'hBF, 8'h00, 8'h00}, ne: 1, e: {21'h7FF,   21'h0},  er: 2'b00};
        vt[13] = '{n: 3, b: {8'hED, 8'h9F, 8'hBF, 8'h00}, ne: 1, e: {21'hD7FF,  21'h0},  er: 2'b00};

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("reset_unicode", unicode, 0);
        check("reset_strobe", unicode_available, 0);
        check("reset_error", decode_error, 0);
        check("reset_byte_ready", byte_ready, 0);
        reset = 1'b0;
        check("byte_ready_low_at_release", byte_ready, 0);
        tick();
        check("byte_ready_rises", byte_ready, 1);

        // Directed vector table
        for (int v = 0; v < 14; v++) begin
            obs.delete();
            for (int i = 0; i < vt[v].n; i++) send(vt[v].b[i], 1'b0);
            wait_obs(vt[v].ne, $sformatf("vec%0d_count", v));
            for (int i = 0; i < vt[v].ne && i < obs.size(); i++) begin
                check($sformatf("vec%0d_cp%0d", v, i), obs[i].cp, vt[v].e[i]);
                check($sformatf("vec%0d_err%0d", v, i), obs[i].err, vt[v].er[i]);
            end
            if (vt[v].ne == 1 && obs.size() > 0)
                check($sformatf("vec%0d_latency", v), obs[0].at, last_accept + 1);
            check_gaps($sformatf("vec%0d_gap", v));
            check($sformatf("vec%0d_idle_ready", v), byte_ready, 1);
        end

        // Back-pressure holds the pending character and blocks input
        obs.delete();
        ready_n = 1'b1;
        send(8'h42, 1'b0);
        repeat (20) tick();
        check("bp_no_strobe", obs.size(), 0);
        check("bp_byte_ready", byte_ready, 0);
        ready_n = 1'b0;
        wait_obs(1, "bp_count");
        if (obs.size() > 0) check("bp_cp", obs[0].cp, 21'h42);

        // Reset mid-sequence discards the partial code point
        obs.delete();
        send(8'hE2, 1'b0);
        send(8'h82, 1'b0);
        reset = 1'b1;
        tick();
        check("midrst_unicode", unicode, 0);
        check("midrst_strobe", unicode_available, 0);
        check("midrst_ready", byte_ready, 0);
        reset = 1'b0;
        tick();
        send(8'h43, 1'b0);
        wait_obs(1, "midrst_count");
        if (obs.size() > 0) begin
            check("midrst_cp", obs[0].cp, 21'h43);
            check("midrst_err", obs[0].err, 0);
        end

        // Randomized streams with idle bytes and random back-pressure
        for (int r = 0; r < 3; r++) begin
            obs.delete();
            gen_stream(60);
            ref_decode(stream);
            rn_rand = 1'b1;
            for (int i = 0; i < stream.size(); i++) send(stream[i], 1'b1);
            rn_rand = 1'b0;
            ready_n = 1'b0;
            wait_obs(exp_cp.size(), $sformatf("rand%0d_count", r));
            for (int i = 0; i < exp_cp.size() && i < obs.size(); i++) begin
                check($sformatf("rand%0d_cp%0d", r, i), obs[i].cp, exp_cp[i]);
                check($sformatf("rand%0d_err%0d", r, i), obs[i].err, exp_err[i]);
            end
            check_gaps($sformatf("rand%0d_gap", r));
        end

        check("stray_error", stray_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
